// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin data-memory arbiter between CPU word accesses and AES 4-word bursts
module dmem_arbiter #(
  parameter int BURST_LEN     = 4,
  parameter bit RR_RESET_LAST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic [31:0]  cpu_addr,
  input  logic [31:0]  cpu_wdata,
  output logic [31:0]  cpu_rdata,
  output logic         cpu_ack,
  input  logic         aes_req,
  input  logic         aes_we,
  input  logic [31:0]  aes_addr,
  input  logic [127:0] aes_wdata,
  output logic [127:0] aes_rdata,
  output logic         aes_done,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic         mem_read,
  output logic         mem_write,
  input  logic [31:0]  mem_rdata
);
  typedef enum logic [1:0] {IDLE, CPU_ACC, AES_ACC, RESP} state_t;
  state_t       state_q, state_d;
  logic [1:0]   beat_q, beat_d;
  logic         last_grant_q, last_grant_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [127:0] wdata_q, wdata_d;
  logic [31:0]  cpu_rdata_q, cpu_rdata_d;
  logic [127:0] aes_rdata_q, aes_rdata_d;
  logic         pick_aes;
  assign pick_aes  = aes_req && (!cpu_req || !last_grant_q);
  assign cpu_rdata = cpu_rdata_q;
  assign aes_rdata = aes_rdata_q;
  // State and latched-request registers; reset aborts any burst in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= 2'd0;
      last_grant_q <= RR_RESET_LAST;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 128'd0;
      cpu_rdata_q  <= 32'd0;
      aes_rdata_q  <= 128'd0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      aes_rdata_q  <= aes_rdata_d;
    end
  end
  // Next-state, grant latching, memory drive and completion pulses
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    aes_rdata_d  = aes_rdata_q;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    cpu_ack      = 1'b0;
    aes_done     = 1'b0;
    case (state_q)
      IDLE: if (cpu_req || aes_req) begin
        state_d      = pick_aes ? AES_ACC : CPU_ACC;
        last_grant_d = pick_aes;
        we_d         = pick_aes ? aes_we : cpu_we;
        addr_d       = pick_aes ? {aes_addr[31:4], 4'b0} : cpu_addr;
        wdata_d      = pick_aes ? aes_wdata : {96'd0, cpu_wdata};
      end
      CPU_ACC: begin
        mem_addr    = addr_q;
        mem_wdata   = wdata_q[31:0];
        mem_read    = !we_q;
        mem_write   = we_q;
        cpu_rdata_d = we_q ? cpu_rdata_q : mem_rdata;
        state_d     = RESP;
      end
      AES_ACC: begin
        mem_addr  = addr_q + {28'd0, beat_q, 2'b00};
        mem_wdata = wdata_q[32*beat_q +: 32];
        mem_read  = !we_q;
        mem_write = we_q;
        if (!we_q) aes_rdata_d[32*beat_q +: 32] = mem_rdata;
        beat_d  = (beat_q == 2'(BURST_LEN - 1)) ? 2'd0 : beat_q + 2'd1;
        state_d = (beat_q == 2'(BURST_LEN - 1)) ? RESP : AES_ACC;
      end
      RESP: begin
        cpu_ack  = !last_grant_q;
        aes_done = last_grant_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: randomized self-checking bench with a word-level memory reference model
module tb_dmem_arbiter;
  logic clk = 0, rst = 1, mem_init = 1;
  logic cpu_req = 0, cpu_we = 0, aes_req = 0, aes_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, aes_addr = 0;
  logic [127:0] aes_wdata = 0;
  logic [31:0] cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic [127:0] aes_rdata;
  logic cpu_ack, aes_done, mem_read, mem_write;
  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] exp_cpu_rdata = 0;
  logic [127:0] exp_aes_rdata = 0;
  bit ref_last = 1;
  int checks = 0, failures = 0;

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .aes_req(aes_req), .aes_we(aes_we), .aes_addr(aes_addr), .aes_wdata(aes_wdata),
    .aes_rdata(aes_rdata), .aes_done(aes_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_init) for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic cpu_op(input logic we, input logic [31:0] a, input logic [31:0] d);
    int n, acts, bad;
    bit got;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    n = 0; acts = 0; bad = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      if (n == 1) begin cpu_addr = $urandom; cpu_wdata = $urandom; cpu_we = ~we; end
      if (mem_read || mem_write) begin
        acts++;
        if (mem_addr !== a || mem_write !== we || mem_read !== !we || (we && mem_wdata !== d)) bad++;
      end
      if (cpu_ack) begin
        got = 1;
        checks++;
        if ({mem_addr, mem_wdata} !== 64'd0) begin failures++; $display("FAIL cpu_resp_mem_idle: got %h required 0", {mem_addr, mem_wdata}); end
      end
    end
    if (we) ref_mem[a[9:2]] = d; else exp_cpu_rdata = ref_mem[a[9:2]];
    ref_last = 0;
    checks++;
    if (n !== 2 || !got) begin failures++; $display("FAIL cpu_ack_latency: got %0d required 2", n); end
    checks++;
    if (acts !== 1 || bad !== 0) begin failures++; $display("FAIL cpu_mem_cycle: acts=%0d bad=%0d required 1/0", acts, bad); end
    checks++;
    if (cpu_rdata !== exp_cpu_rdata) begin failures++; $display("FAIL cpu_rdata: got %h required %h", cpu_rdata, exp_cpu_rdata); end
    cpu_req = 0;
    @(negedge clk);
  endtask

  task automatic aes_op(input logic we, input logic [31:0] a, input logic [127:0] d);
    logic [31:0] base;
    int n, beats, bad;
    bit got;
    base = {a[31:4], 4'b0};
    aes_req = 1; aes_we = we; aes_addr = a; aes_wdata = d;
    n = 0; beats = 0; bad = 0; got = 0;
    while (n < 20 && !got) begin
      @(negedge clk); n++;
      if (n == 2) begin aes_addr = $urandom; aes_wdata = {4{$urandom}}; aes_we = ~we; end
      if (mem_read || mem_write) begin
        if (beats > 3 || mem_addr !== base + 32'(4 * beats) || mem_write !== we || mem_read !== !we) bad++;
        else if (we && mem_wdata !== d[32*beats +: 32]) bad++;
        beats++;
      end
      if (aes_done) got = 1;
    end
    for (int k = 0; k < 4; k++)
      if (we) ref_mem[base[9:2] + k] = d[32*k +: 32]; else exp_aes_rdata[32*k +: 32] = ref_mem[base[9:2] + k];
    ref_last = 1;
    checks++;
    if (n !== 5 || !got) begin failures++; $display("FAIL aes_done_latency: got %0d required 5", n); end
    checks++;
    if (beats !== 4 || bad !== 0) begin failures++; $display("FAIL aes_beats: beats=%0d bad=%0d required 4/0", beats, bad); end
    checks++;
    if (aes_rdata !== exp_aes_rdata) begin failures++; $display("FAIL aes_rdata: got %h required %h", aes_rdata, exp_aes_rdata); end
    aes_req = 0;
    @(negedge clk);
  endtask

  task automatic race(input logic [31:0] ca, input logic [31:0] cd, input logic [31:0] aa, input logic [127:0] ad);
    int n, cpu_at, aes_at, exp_cpu, exp_aes;
    bit cpu_first;
    cpu_first = ref_last;
    exp_cpu = cpu_first ? 2 : 8;
    exp_aes = cpu_first ? 8 : 5;
    cpu_req = 1; cpu_we = 1; cpu_addr = ca; cpu_wdata = cd;
    aes_req = 1; aes_we = 1; aes_addr = aa; aes_wdata = ad;
    n = 0; cpu_at = -1; aes_at = -1;
    while (n < 40 && (cpu_at < 0 || aes_at < 0)) begin
      @(negedge clk); n++;
      if (cpu_ack) begin cpu_at = n; cpu_req = 0; end
      if (aes_done) begin aes_at = n; aes_req = 0; end
    end
    if (cpu_first) begin
      ref_mem[ca[9:2]] = cd;
      for (int k = 0; k < 4; k++) ref_mem[aa[9:4] * 4 + k] = ad[32*k +: 32];
    end else begin
      for (int k = 0; k < 4; k++) ref_mem[aa[9:4] * 4 + k] = ad[32*k +: 32];
      ref_mem[ca[9:2]] = cd;
    end
    ref_last = !cpu_first;
    checks++;
    if (cpu_at !== exp_cpu) begin failures++; $display("FAIL race_cpu_ack: got %0d required %0d", cpu_at, exp_cpu); end
    checks++;
    if (aes_at !== exp_aes) begin failures++; $display("FAIL race_aes_done: got %0d required %0d", aes_at, exp_aes); end
    @(negedge clk);
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if ({mem_read, mem_write, cpu_ack, aes_done} !== 4'd0) begin failures++; $display("FAIL reset_ctrl: got %b required 0000", {mem_read, mem_write, cpu_ack, aes_done}); end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin failures++; $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata}); end
    checks++;
    if (cpu_rdata !== 32'd0 || aes_rdata !== 128'd0) begin failures++; $display("FAIL reset_rdata: got %h %h required 0", cpu_rdata, aes_rdata); end
  endtask

  task automatic test_cpu_basic;
    cpu_op(1, 32'h10, 32'hDEADBEEF);
    cpu_op(0, 32'h10, 32'h0);
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL cpu_readback: got %h required deadbeef", cpu_rdata); end
  endtask

  task automatic test_aes_basic;
    logic [127:0] blk;
    blk = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    aes_op(1, 32'h23, blk);
    checks++;
    if (mem[8] !== 32'hCCDDEEFF || mem[11] !== 32'h00112233) begin failures++; $display("FAIL aes_word_order: got %h %h required ccddeeff 00112233", mem[8], mem[11]); end
    aes_op(0, 32'h20, 128'd0);
    checks++;
    if (aes_rdata !== blk) begin failures++; $display("FAIL aes_readback: got %h required %h", aes_rdata, blk); end
  endtask

  task automatic test_round_robin;
    race(32'h100, $urandom, 32'h200, {$urandom, $urandom, $urandom, $urandom});
    cpu_op(1, 32'h104, $urandom);
    race(32'h108, $urandom, 32'h210, {$urandom, $urandom, $urandom, $urandom});
    cpu_op(0, 32'h108, 32'h0);
    aes_op(0, 32'h210, 128'd0);
  endtask

  task automatic test_cpu_during_burst;
    logic [127:0] blk;
    int n, done_at, ack_at, acts_before;
    blk = {$urandom, $urandom, $urandom, $urandom};
    aes_req = 1; aes_we = 1; aes_addr = 32'h300; aes_wdata = blk;
    n = 0; done_at = -1; ack_at = -1; acts_before = 0;
    while (n < 30 && ack_at < 0) begin
      @(negedge clk); n++;
      if (n == 2) begin cpu_req = 1; cpu_we = 0; cpu_addr = 32'h304; end
      if ((mem_read || mem_write) && done_at < 0) acts_before++;
      if (aes_done) begin done_at = n; aes_req = 0; end
      if (cpu_ack) begin ack_at = n; cpu_req = 0; end
    end
    for (int k = 0; k < 4; k++) ref_mem[8'hC0 + k] = blk[32*k +: 32];
    exp_cpu_rdata = ref_mem[8'hC1];
    ref_last = 0;
    checks++;
    if (done_at !== 5 || acts_before !== 4) begin failures++; $display("FAIL burst_uninterrupted: done=%0d acts=%0d required 5/4", done_at, acts_before); end
    checks++;
    if (ack_at - done_at !== 3) begin failures++; $display("FAIL cpu_after_burst: got %0d required 3", ack_at - done_at); end
    checks++;
    if (cpu_rdata !== exp_cpu_rdata) begin failures++; $display("FAIL cpu_read_after_burst: got %h required %h", cpu_rdata, exp_cpu_rdata); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    logic [127:0] blk;
    int n, dones;
    blk = {$urandom, $urandom, $urandom, $urandom};
    aes_req = 1; aes_we = 1; aes_addr = 32'h380; aes_wdata = blk;
    n = 0;
    while (n < 3) begin @(negedge clk); n++; end
    rst = 1;
    #1;
    checks++;
    if ({mem_read, mem_write} !== 2'b00 || {mem_addr, mem_wdata} !== 64'd0) begin failures++; $display("FAIL reset_mid_burst_bus: got %b %h required 0", {mem_read, mem_write}, {mem_addr, mem_wdata}); end
    dones = 0;
    aes_req = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (aes_done) dones++; end
    rst = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (aes_done) dones++; end
    ref_mem[8'hE0] = blk[31:0];
    ref_mem[8'hE1] = blk[63:32];
    ref_last = 1; exp_cpu_rdata = 0; exp_aes_rdata = 0;
    checks++;
    if (dones !== 0) begin failures++; $display("FAIL reset_no_done: got %0d required 0", dones); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (mem[8'hE0 + k] !== ref_mem[8'hE0 + k]) begin failures++; $display("FAIL reset_partial_word%0d: got %h required %h", k, mem[8'hE0 + k], ref_mem[8'hE0 + k]); end
    end
    checks++;
    if (cpu_rdata !== exp_cpu_rdata || aes_rdata !== exp_aes_rdata) begin failures++; $display("FAIL reset_rdata_clear: got %h %h required 0", cpu_rdata, aes_rdata); end
  endtask

  task automatic test_hold_req;
    int n, acks, acts;
    logic [31:0] d;
    cpu_op(1, 32'h3F0, 32'h1234_5678);
    acts = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (mem_read || mem_write || cpu_ack) acts++; end
    checks++;
    if (acts !== 0) begin failures++; $display("FAIL no_double_serve: got %0d required 0", acts); end
    d = $urandom;
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h3F4; cpu_wdata = d;
    n = 0; acks = 0;
    while (n < 20 && acks < 2) begin
      @(negedge clk); n++;
      if (cpu_ack) acks++;
    end
    cpu_req = 0;
    ref_mem[8'hFD] = d;
    ref_last = 0;
    checks++;
    if (n !== 5 || acks !== 2) begin failures++; $display("FAIL held_req_second_grant: got %0d acks at %0d required 2 at 5", acks, n); end
    @(negedge clk);
    cpu_op(0, 32'h3F4, 32'h0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) cpu_op(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
      else aes_op(1'($urandom_range(0, 1)), {22'd0, 6'($urandom_range(0, 63)), 4'($urandom)}, {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    repeat (2) @(negedge clk);
    test_reset;
    mem_init = 0;
    rst = 0;
    @(negedge clk);
    test_cpu_basic;
    test_aes_basic;
    test_round_robin;
    test_cpu_during_burst;
    test_reset_mid_burst;
    test_hold_req;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
